// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the field widths, the opcode/funct constants, the ALU select codes,
// the FSM state encoding and the packed control-word struct that groups
// every datapath strobe and select driven by the controller.
package mips_pkg;

    localparam int OP_WIDTH  = 6;
    localparam int SEL_WIDTH = 2;

    // Opcodes (IR[31:26])
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'h02;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [OP_WIDTH-1:0] FN_ADD = 6'h20;
    localparam logic [OP_WIDTH-1:0] FN_SUB = 6'h22;
    localparam logic [OP_WIDTH-1:0] FN_AND = 6'h24;
    localparam logic [OP_WIDTH-1:0] FN_OR  = 6'h25;

    // ALU select codes
    localparam logic [SEL_WIDTH-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_WIDTH-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_WIDTH-1:0] ALU_AND = 2'b10;
    localparam logic [SEL_WIDTH-1:0] ALU_OR  = 2'b11;

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        ADDI_EX  = 4'd11,
        ADDI_WB  = 4'd12
    } state_t;

    // One control word per cycle; all-zero is the idle/safe value.
    typedef struct packed {
        logic [SEL_WIDTH-1:0] alu_load;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic [1:0]           pc_source;
        logic                 pc_write;
        logic                 ir_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 iord;
        logic                 reg_write;
        logic                 reg_dst;
        logic                 mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle for the multi-cycle MIPS core.
// master: the controller (consumes opcode/funct/zeroflag, drives strobes).
// slave : the datapath side (drives opcode/funct/zeroflag, consumes strobes).
//   opcode, funct  instruction register fields
//   zeroflag       ALU zero flag, meaningful while alu_load=SUB
//   alu_load       ALU operation select
//   alu_src_a/b, pc_source, pc_write, ir_write, mem_read, mem_write,
//   iord, reg_write, reg_dst, mem_to_reg   datapath strobes/selects
//   illegal_op     sticky unsupported-instruction flag
//   state_o        current FSM state for debug
interface mips_multicycle_control_if #(
    parameter int OP_WIDTH  = mips_pkg::OP_WIDTH,
    parameter int SEL_WIDTH = mips_pkg::SEL_WIDTH
) ();
    logic [OP_WIDTH-1:0]  opcode;
    logic [OP_WIDTH-1:0]  funct;
    logic                 zeroflag;
    logic [SEL_WIDTH-1:0] alu_load;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           pc_source;
    logic                 pc_write;
    logic                 ir_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 iord;
    logic                 reg_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 illegal_op;
    logic [3:0]           state_o;

    modport master (
        input  opcode, funct, zeroflag,
        output alu_load, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               illegal_op, state_o
    );

    modport slave (
        output opcode, funct, zeroflag,
        input  alu_load, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
               illegal_op, state_o
    );
endinterface

// File: rtl/mips_multicycle_control_alu_funct_decode.sv
// Combinational R-type funct decoder.
//   funct        in   IR[5:0]
//   alu_load     out  ALU select for the funct (ADD when unsupported)
//   funct_valid  out  1 when funct is add/sub/and/or
module alu_funct_decode
    import mips_pkg::*;
(
    input  logic [OP_WIDTH-1:0]  funct,
    output logic [SEL_WIDTH-1:0] alu_load,
    output logic                 funct_valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_load    = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_load = ALU_ADD;
            FN_SUB:  alu_load = ALU_SUB;
            FN_AND:  alu_load = ALU_AND;
            FN_OR:   alu_load = ALU_OR;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// strobes plus the 2-bit ALU select. Outputs are Moore decodes of the
// registered state, except pc_write in BRANCH which follows zeroflag in
// the same cycle.
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   bus   master side of mips_multicycle_control_if
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    mips_multicycle_control_if.master   bus
);

    state_t               state_q;
    state_t               state_d;
    ctrl_t                ctrl;
    logic                 set_illegal;
    logic                 illegal_q;
    logic [SEL_WIDTH-1:0] funct_sel;
    logic                 funct_valid;

    alu_funct_decode u_funct_decode (
        .funct       (bus.funct),
        .alu_load    (funct_sel),
        .funct_valid (funct_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (set_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = FETCH;
        set_illegal = 1'b0;
        case (state_q)
            RESET:  state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default: begin
                        state_d     = FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                if (funct_valid) begin
                    state_d = R_WB;
                end else begin
                    state_d     = FETCH;
                    set_illegal = 1'b1;
                end
            end
            // Only lw and sw reach MEM_ADDR, so anything but lw is a store.
            MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = MEM_WB;
            ADDI_EX:  state_d = ADDI_WB;
            // R_WB, MEM_WB, MEM_WR, BRANCH, JUMP, ADDI_WB and any
            // unreachable encoding all return to FETCH.
            default:  state_d = FETCH;
        endcase
    end

    // Output decode; RESET and unreachable encodings keep the all-zero word.
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_write  = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_load  = funct_sel;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            MEM_ADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_load  = ALU_SUB;
                ctrl.pc_source = 2'b01;
                // zeroflag is the SUB result of this very cycle.
                ctrl.pc_write  = bus.zeroflag;
            end
            JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_write  = 1'b1;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign bus.alu_load   = ctrl.alu_load;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.iord       = ctrl.iord;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.illegal_op = illegal_q;
    assign bus.state_o    = state_q;

endmodule
